// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block-type codes, pad FSM states, length limits and the IV.
package sha256_pkg;

    localparam int MAX_LEN = 119;

    // Longest message whose 0x80 marker and length field still fit in one block.
    localparam logic [6:0] ONE_BLK_MAX = 7'd55;

    localparam logic [1:0] HASH        = 2'd0;
    localparam logic [1:0] MERKLE_LEAF = 2'd1;
    localparam logic [1:0] HEADER      = 2'd2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        START   = 2'd2,
        BUSY    = 2'd3
    } pad_state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_byte_packer.sv
// 128-byte big-endian message buffer: byte writes, clear, and padding insertion.
module sha256_byte_packer
    import sha256_pkg::*;
(
    input  logic          CLK,
    input  logic          nreset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [6:0]    wr_idx,
    input  logic [7:0]    wr_data,
    input  logic          pad_en,
    input  logic [6:0]    pad_len,
    output logic [1023:0] buf_q,
    output logic [1023:0] pad_view
);

    logic [9:0]  wr_hi;
    logic [9:0]  pad_hi;
    logic [63:0] len_bits;

    // Byte n of the buffer occupies bits [1023-8n -: 8].
    assign wr_hi    = 10'd1023 - {wr_idx, 3'b000};
    assign pad_hi   = 10'd1023 - {pad_len, 3'b000};
    assign len_bits = {54'd0, pad_len, 3'b000};

    // The padded view is combinational so the first block can be loaded on the same edge the pad is stored.
    always_comb begin
        pad_view = buf_q;
        pad_view[pad_hi -: 8] = 8'h80;
        if (pad_len <= ONE_BLK_MAX) begin
            pad_view[575:512] = len_bits;
        end else begin
            pad_view[63:0] = len_bits;
        end
    end

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            buf_q <= '0;
        end else if (clr) begin
            buf_q <= '0;
        end else if (pad_en) begin
            buf_q <= pad_view;
        end else if (wr_en) begin
            buf_q[wr_hi -: 8] <= wr_data;
        end
    end

endmodule

// File: rtl/sha256_msg_pad.sv
// Byte-stream front end for the SHA-256 core: collects, pads and sequences 1- or 2-block messages.
// Build option SHA256_MSG_PAD_DOUBLE_EN hashes the first digest again (double SHA-256).
//
// state   | meaning
// COLLECT | accepting message bytes
// PAD     | insert 0x80 and length, load block 0
// START   | one-cycle start pulse to the core
// BUSY    | waiting for blk_done
module sha256_msg_pad
    import sha256_pkg::*;
(
    input  logic         CLK,
    input  logic         nreset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic         start,
    output logic [511:0] msg,
    output logic [1:0]   blk_type,
    input  logic         blk_done,
    input  logic [255:0] hash,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         err
);

    pad_state_t    state_q, state_d;
    logic [6:0]    cnt_q;
    logic [6:0]    len_q;
    logic          ovf_q;
    logic          second_q;
    logic          accept;
    logic          ovf_hit;
    logic          blk_first;
    logic          blk_last;
    logic          blk_final;
    logic          rehash;
    logic          wr_en;
    logic          pad_en;
    logic          buf_clr;
    logic [1023:0] buf_q;
    logic [1023:0] pad_view;

    assign in_ready  = (state_q == COLLECT);
    assign start     = (state_q == START);
    assign accept    = in_valid & in_ready;
    assign ovf_hit   = ovf_q | (cnt_q == 7'(MAX_LEN));
    assign blk_first = (state_q == BUSY) & blk_done & (blk_type == HEADER) & ~second_q;
    assign blk_last  = (state_q == BUSY) & blk_done & ~blk_first;

`ifdef SHA256_MSG_PAD_DOUBLE_EN
    logic pass2_q;
    assign rehash = blk_last & ~pass2_q;
`else
    assign rehash = 1'b0;
`endif
    assign blk_final = blk_last & ~rehash;

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        pad_en  = 1'b0;
        buf_clr = 1'b0;
        case (state_q)
            COLLECT: begin
                wr_en = accept & ~ovf_q;
                if (accept && in_last) begin
                    if (ovf_hit) begin
                        buf_clr = 1'b1;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                pad_en  = 1'b1;
                state_d = START;
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (rehash) begin
                    state_d = START;
                end else if (blk_final) begin
                    buf_clr = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            cnt_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            second_q     <= 1'b0;
            msg          <= '0;
            blk_type     <= HASH;
            digest       <= '0;
            digest_valid <= 1'b0;
            err          <= 1'b0;
`ifdef SHA256_MSG_PAD_DOUBLE_EN
            pass2_q      <= 1'b0;
`endif
        end else begin
            digest_valid <= 1'b0;
            err          <= 1'b0;
            if (accept) begin
                if (in_last && ovf_hit) begin
                    err   <= 1'b1;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else if (in_last) begin
                    len_q <= cnt_q + 7'd1;
                end else if (!ovf_q) begin
                    if (cnt_q == 7'(MAX_LEN)) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
            end
            if (state_q == PAD) begin
                msg      <= pad_view[1023:512];
                blk_type <= (len_q <= ONE_BLK_MAX) ? HASH : HEADER;
                second_q <= 1'b0;
`ifdef SHA256_MSG_PAD_DOUBLE_EN
                pass2_q  <= 1'b0;
`endif
            end
            if (blk_first) begin
                msg      <= buf_q[511:0];
                second_q <= 1'b1;
            end
`ifdef SHA256_MSG_PAD_DOUBLE_EN
            // Second pass hashes the 32-byte first digest as a single padded block.
            if (rehash) begin
                msg      <= {hash, 8'h80, 184'd0, 64'd256};
                blk_type <= HASH;
                pass2_q  <= 1'b1;
            end
`endif
            if (blk_final) begin
                digest       <= hash;
                digest_valid <= 1'b1;
                cnt_q        <= '0;
            end
        end
    end

    sha256_byte_packer u_packer (
        .CLK      (CLK),
        .nreset   (nreset),
        .clr      (buf_clr),
        .wr_en    (wr_en),
        .wr_idx   (cnt_q),
        .wr_data  (in_data),
        .pad_en   (pad_en),
        .pad_len  (len_q),
        .buf_q    (buf_q),
        .pad_view (pad_view)
    );

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Bench for sha256_msg_pad with a behavioural SHA-256 core and a digest scoreboard.
module tb_sha256_msg_pad;
    import sha256_pkg::*;

    typedef logic [7:0] bq_t [$];

    localparam int CORE_LAT = 6;
    localparam int DV_LIMIT = 400;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam string GENESIS = {
        "01000000",
        "0000000000000000000000000000000000000000000000000000000000000000",
        "3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a",
        "29ab5f49", "ffff001d", "1dac2b7c"
    };

    logic         CLK = 1'b0;
    logic         nreset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         start;
    logic [511:0] msg;
    logic [1:0]   blk_type;
    logic         blk_done;
    logic [255:0] hash;
    logic [255:0] digest;
    logic         digest_valid;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_err = 0;
    int n_dv = 0;
    int n_rdy_low = 0;
    logic [255:0] exp_q [$];
    logic [255:0] core_h;
    logic [1:0]   core_type;
    logic [511:0] core_msg1 = '0;

    sha256_msg_pad dut (
        .CLK          (CLK),
        .nreset       (nreset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .start        (start),
        .msg          (msg),
        .blk_type     (blk_type),
        .blk_done     (blk_done),
        .hash         (hash),
        .digest       (digest),
        .digest_valid (digest_valid),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = h_in;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + h_in[255:224], b + h_in[223:192], c + h_in[191:160], d + h_in[159:128],
                e + h_in[127:96],  f + h_in[95:64],   g + h_in[63:32],   h + h_in[31:0]};
    endfunction

    function automatic void pad_ref(input bq_t m, output logic [511:0] b0, output logic [511:0] b1, output int nblk);
        bq_t p;
        logic [63:0] bits;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < 64; i++) b0[511 - 8*i -: 8] = p[i];
        if (nblk > 1) for (int i = 0; i < 64; i++) b1[511 - 8*i -: 8] = p[64 + i];
    endfunction

    function automatic logic [255:0] sha_ref(input bq_t m);
        logic [511:0] b0, b1;
        int nblk;
        logic [255:0] h;
        pad_ref(m, b0, b1, nblk);
        h = compress(SHA256_IV, b0);
        if (nblk == 2) h = compress(h, b1);
        return h;
    endfunction

    function automatic bq_t d2q(input logic [255:0] d);
        bq_t q;
        for (int i = 0; i < 32; i++) q.push_back(d[255 - 8*i -: 8]);
        return q;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] c);
        return c[6] ? c[3:0] + 4'd9 : c[3:0];
    endfunction

    function automatic bq_t hex2q(input string s);
        bq_t q;
        for (int i = 0; i + 1 < s.len(); i += 2) q.push_back({nib(s[i]), nib(s[i+1])});
        return q;
    endfunction

    function automatic bq_t rand_q(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Behavioural core: one block per start, second block sampled two cycles after the first blk_done.
    initial begin
        blk_done = 1'b0;
        hash     = '0;
        forever begin
            if (nreset === 1'b1 && start === 1'b1) begin
                core_type = blk_type;
                core_h    = compress(SHA256_IV, msg);
                repeat (CORE_LAT) @(posedge CLK);
                #1;
                blk_done = 1'b1; hash = core_h;
                @(posedge CLK); #1;
                blk_done = 1'b0; hash = ~core_h;
                if (core_type == HEADER) begin
                    @(posedge CLK); #1;
                    core_msg1 = msg;
                    core_h    = compress(core_h, msg);
                    repeat (CORE_LAT) @(posedge CLK);
                    #1;
                    blk_done = 1'b1; hash = core_h;
                    @(posedge CLK); #1;
                    blk_done = 1'b0; hash = ~core_h;
                end
            end else begin
                @(posedge CLK); #1;
            end
        end
    end

    always @(negedge CLK) begin
        if (nreset === 1'b1) begin
            if (start === 1'b1) n_start <= n_start + 1;
            if (err === 1'b1) n_err <= n_err + 1;
            if (digest_valid === 1'b1) n_dv <= n_dv + 1;
            if (in_ready !== 1'b1) n_rdy_low <= n_rdy_low + 1;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        check($sformatf("%s_ctl", tag), 512'({start, digest_valid, err, in_ready, blk_type}), 512'(6'b000100));
        check($sformatf("%s_msg", tag), msg, 512'd0);
        check($sformatf("%s_digest", tag), 512'(digest), 512'd0);
    endtask

    task automatic send(input bq_t m, input bit gap);
        int waitc;
        for (int i = 0; i < m.size(); i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0; in_last = 1'b0;
                @(posedge CLK); #1;
            end
            in_data  = m[i];
            in_valid = 1'b1;
            in_last  = (i == m.size() - 1);
            waitc = 0;
            while (in_ready !== 1'b1 && waitc < 50) begin
                @(posedge CLK); #1;
                waitc++;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    task automatic hash_msg(input string tag, input bq_t m, input bit gap,
                            output logic [255:0] dig, output logic [511:0] first_msg);
        logic [511:0] b0, b1;
        int nblk, s0, d0;
        logic [255:0] exp_d;
        bit got;
        pad_ref(m, b0, b1, nblk);
        exp_d = sha_ref(m);
`ifdef SHA256_MSG_PAD_DOUBLE_EN
        exp_d = sha_ref(d2q(exp_d));
`endif
        exp_q.push_back(exp_d);
        s0 = n_start;
        d0 = n_dv;
        send(m, gap);
        check($sformatf("%s_rdy_pad", tag), 512'(in_ready), 512'd0);
        check($sformatf("%s_start_pad", tag), 512'(start), 512'd0);
        @(posedge CLK); #1;
        first_msg = msg;
        check($sformatf("%s_start", tag), 512'(start), 512'd1);
        check($sformatf("%s_msg0", tag), msg, b0);
        check($sformatf("%s_type", tag), 512'(blk_type), 512'((nblk == 2) ? HEADER : HASH));
        got = 1'b0;
        dig = '0;
        for (int i = 0; i < DV_LIMIT && !got; i++) begin
            @(posedge CLK); #1;
            if (digest_valid === 1'b1) got = 1'b1;
        end
        check($sformatf("%s_dv_seen", tag), 512'(got), 512'd1);
        if (got) begin
            dig = digest;
            check($sformatf("%s_rdy_dv", tag), 512'(in_ready), 512'd1);
            check($sformatf("%s_digest", tag), 512'(digest), 512'(exp_q.pop_front()));
        end else begin
            void'(exp_q.pop_front());
        end
        repeat (8) @(posedge CLK);
        #1;
        check($sformatf("%s_dv_count", tag), 512'(n_dv - d0), 512'd1);
`ifdef SHA256_MSG_PAD_DOUBLE_EN
        check($sformatf("%s_starts", tag), 512'(n_start - s0), 512'd2);
`else
        check($sformatf("%s_starts", tag), 512'(n_start - s0), 512'd1);
`endif
        if (nblk == 2) check($sformatf("%s_msg1", tag), core_msg1, b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dig;
        logic [511:0] m0;
        int s0, e0, r0, d0;

        nreset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        reset_chk("por");
        nreset = 1'b1;
        @(posedge CLK); #1;

        hash_msg("abc", str2q("abc"), 1'b0, dig, m0);
`ifndef SHA256_MSG_PAD_DOUBLE_EN
        check("abc_known", 512'(dig), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
`endif

        hash_msg("m56", str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, dig, m0);
        check("m56_len_field", 512'(core_msg1[63:0]), 512'(64'h1c0));
`ifndef SHA256_MSG_PAD_DOUBLE_EN
        check("m56_known", 512'(dig), 512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));
`endif

        hash_msg("hdr80", hex2q(GENESIS), 1'b0, dig, m0);
`ifdef SHA256_MSG_PAD_DOUBLE_EN
        check("genesis_known", 512'(dig), 512'(256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000));
`endif

        // Overflow: 120 bytes with in_last on the last one.
        s0 = n_start; e0 = n_err; r0 = n_rdy_low;
        send(rand_q(120), 1'b0);
        check("ovf_err_pulse", 512'(err), 512'd1);
        check("ovf_rdy", 512'(in_ready), 512'd1);
        repeat (20) @(posedge CLK);
        #1;
        check("ovf_err_count", 512'(n_err - e0), 512'd1);
        check("ovf_no_start", 512'(n_start - s0), 512'd0);
        check("ovf_rdy_held", 512'(n_rdy_low - r0), 512'd0);
        hash_msg("abc_after_ovf", str2q("abc"), 1'b0, dig, m0);

        // Reset while the first block of a two-block message is in the core.
        s0 = n_start;
        send(rand_q(70), 1'b0);
        for (int i = 0; i < 50 && n_start == s0; i++) begin
            @(posedge CLK); #1;
        end
        check("rst_started", 512'(n_start - s0), 512'd1);
        repeat (2) @(posedge CLK);
        #1;
        nreset = 1'b0;
        #1;
        reset_chk("rst_busy");
        @(posedge CLK); #1;
        nreset = 1'b1;
        d0 = n_dv;
        repeat (30) @(posedge CLK);
        #1;
        check("rst_no_dv", 512'(n_dv - d0), 512'd0);
        check("rst_rdy", 512'(in_ready), 512'd1);
        hash_msg("abc_after_rst", str2q("abc"), 1'b0, dig, m0);

        hash_msg("gap55", rand_q(55), 1'b1, dig, m0);
        check("gap55_len_field", 512'(m0[63:0]), 512'(64'h1b8));

        hash_msg("max119", rand_q(MAX_LEN), 1'b0, dig, m0);
        hash_msg("one", rand_q(1), 1'b0, dig, m0);

        check("sb_empty", 512'(exp_q.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_pad.md
# sha256_msg_pad

Upstream feeder for the SHA256 compression core. It accepts a byte stream with valid/ready handshaking and packs bytes big-endian into a 1024-bit buffer. It applies FIPS 180-4 padding and the 64-bit length field, then drives the core's `start`/`msg`/`blk_type` inputs and follows `blk_done` to present a second block when one is needed. It captures the core's `hash` as the message digest and supports messages of 1 to 119 bytes, which covers 1- and 2-block cases, including the 80-byte block header.

## Interface
- MAX_LEN, 119: largest accepted message in bytes; fixed by the core's two-block limit.
- CLK  input  1  clock, rising edge.
- nreset  input  1  reset; asynchronous assert, active-low.
- in_data  input  8  message byte.
- in_valid  input  1  byte valid.
- in_last  input  1  marks the final byte of the message.
- in_ready  output  1  byte accepted when `in_valid & in_ready`; equals (state==COLLECT).
- start  output  1  one-cycle pulse to the core.
- msg  output  512  block to the core; byte 0 of the block sits at [511:504].
- blk_type  output  2  0 = HASH (1 block), 2 = HEADER (2 blocks).
- blk_done  input  1  from the core; `hash` is valid in the same cycle.
- hash  input  256  from the core.
- digest  output  256  final digest; holds its value until the next digest.
- digest_valid  output  1  one-cycle pulse.
- err  output  1  one-cycle pulse on an overflowed message.

## Operation
- States: COLLECT, PAD, START, BUSY. The reset state is COLLECT.
- Reset values: start=0, msg=0, blk_type=0, digest=0, digest_valid=0, err=0, buffer=0, cnt=0. in_ready is 1 while in COLLECT.
- COLLECT
  - Each accepted byte is written at buffer byte index cnt, and cnt increments (7-bit).
  - When the byte is accepted with in_last, latch len=cnt+1 and go to PAD.
  - A byte accepted at cnt==119 sets the ovf flag. Later bytes are discarded until in_last.
  - When in_last arrives with ovf set: pulse err, clear the buffer, cnt and ovf, and stay in COLLECT.
- PAD (one cycle)
  - Write 0x80 at index len.
  - Write the 64-bit big-endian value len*8 at bytes 56..63 if len<=55 (blk_type=0). Otherwise write it at bytes 120..127 (blk_type=2).
  - Load msg with block 0 and go to START.
- START: start=1 for exactly one cycle, then go to BUSY.
- BUSY
  - On blk_done for the first block of a 2-block message, load msg with block 1 on that same edge. The core samples msg two cycles later. Stay in BUSY.
  - On blk_done for the final block: digest<=hash, pulse digest_valid, clear buffer/cnt, and return to COLLECT.
- A blk_done seen outside BUSY is ignored.
- Lengths 1..55 produce one block; 56..119 produce two blocks. A 0-length message is not expressible.
- Reset mid-operation returns everything to the reset values immediately. A partially collected message is lost.

## Timing
- Byte throughput is 1 byte/cycle in COLLECT.
- in_last accepted at edge T: PAD during T..T+1, start high during cycle T+2, in_ready low from T+1 until the return to COLLECT.
- msg is stable from the PAD edge until the next blk_done edge.
- digest_valid is asserted in the cycle after the final blk_done.
- in_ready rises in the same cycle as digest_valid. A new byte may be accepted in that cycle.
- err rises on the cycle after the edge that accepted in_last. No start is issued for that message.

## Configuration
- `SHA256_MSG_PAD_DOUBLE_EN` defined: Bitcoin double-SHA mode.
  - On the final blk_done of the first pass, do not assert digest_valid.
  - Load msg with {hash, 0x80, 23 zero bytes, 64'd256}, set blk_type=0, then pass through START and BUSY again.
  - digest and digest_valid reflect only the second pass.
- Undefined: single SHA-256, behaving as described above.

## Structure
- Shared package `sha256_pkg`:
  - blk_type constants HASH=2'd0, MERKLE_LEAF=2'd1, HEADER=2'd2;
  - state encoding;
  - MAX_LEN=119;
  - SHA-256 IV constants shared with the core.
- One sub-module, `sha256_byte_packer`: a 128-byte buffer with byte-indexed write, clear, and the PAD insertion of 0x80 and the length field. The FSM stays in the top.

## Test plan
- "abc" (3 bytes, in_last on the third) -> start once, blk_type=0, msg=616263800…0018; digest ba7816bf…f20015ad.
- 56-byte "abcdbcde…nopq" -> blk_type=2; second msg ends in 64'h1c0; digest 248d6a61…19db06c1.
- 80-byte Bitcoin genesis header with `SHA256_MSG_PAD_DOUBLE_EN` -> digest 6fe28c0a…(byte-reversed); exactly one digest_valid.
- 120 bytes, in_last on the 120th -> no start, err pulse, in_ready held at 1; a following "abc" hashes correctly.
- Reset asserted in BUSY during the first block of a 2-block message -> all outputs at reset values; a following "abc" is correct.
- in_valid gapped every other cycle on a 55-byte message -> one block, length 64'h1b8 at bytes 56..63, digest matches the reference model.
